mux_data_flow: RTL and testbench
================================

# mux_data_flow

Two-input multiplexer written in dataflow (continuous-assignment) style, with a registered copy of its output and a select-activity counter. It is the reference 2:1 selector in the datapath library: combinational consumers use `out`; clocked consumers use the one-cycle-delayed `out_q`. Equivalent structural and behavioural variants must match its combinational behaviour bit for bit.

## Interface
- `WIDTH`, default 1: data width of `inA`, `inB`, `out`, `out_q`.
- `CNT_W`, default 8: width of the select-change counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `inA` input WIDTH: data input selected when `sel` = 0.
- `inB` input WIDTH: data input selected when `sel` = 1.
- `sel` input 1: select.
- `out` output WIDTH: combinational mux result.
- `out_q` output WIDTH: `out` registered on `clk`.
- `sel_changes` output CNT_W: count of clock edges where the sampled `sel` differs from its previous sampled value.

## Operation
- `out = sel ? inB : inA`, as a single continuous assignment with no storage.
  - It is independent of `clk` and `rst`.
  - It is valid during reset.
- If `sel` is X or Z, `out` follows Verilog `?:` semantics: matching bits pass and differing bits go to X. No special handling.
- `out_q` captures `out` on every rising `clk`. There is no enable.
- `sel_q` is an internal register that captures `sel` on every rising `clk`.
- `sel_changes` increments by 1 on a rising edge when `sel != sel_q`.
  - It wraps from 2^CNT_W−1 to 0.
  - There is no saturation flag.
- Reset values, applied immediately on `rst` rising (asynchronous):
  - `out_q` = 0
  - `sel_q` = 0
  - `sel_changes` = 0
- Reset release is synchronous to the next rising `clk`. The first post-reset edge compares `sel` against `sel_q` = 0, so `sel` = 1 at that edge counts as one change.

## Timing
- `out`: zero-cycle, purely combinational path from `inA`, `inB` and `sel`.
- `out_q`: one-cycle latency. The value at edge n+1 equals `out` sampled at edge n.
- `sel_changes`: updates one edge after `sel` is sampled different from `sel_q`.
  - At most +1 per edge.
  - A `sel` pulse that starts and ends between two edges is not counted.
- Reset mid-operation: registered outputs go to 0 within the same timestep. `out` keeps tracking its inputs.
- Input changes coincident with `clk` follow standard setup/hold. The bench drives inputs away from clock edges.

## Structure
- Shared package `mux_pkg`:
  - default `WIDTH` and `CNT_W` constants.
  - a function `mux2(a, b, s)` returning `s ? b : a`. The structural and behavioural variants use it as their golden model.
- One natural sub-module, `mux2_comb`: the dataflow assignment only, parameterised by `WIDTH`. The top instantiates it and adds the registers and counter.
- No state machine. There are three register groups: `out_q`, `sel_q` and `sel_changes`.

## Test plan
1. Static select: `sel` = 0, `inA` toggles every 10 ns, `inB` every 50 ns, starting at 0 → `out` equals `inA` at all times (0→1 at 10 ns, 1→0 at 20 ns, and so on).
2. Select flip: `sel` goes 0→1 at 200 ns with the same stimulus → from 200 ns `out` equals `inB`. At 210 ns `inB` = 0, so `out` = 0; at 250 ns `out` = 1. At 400 ns `sel` returns to 0 and `out` follows `inA` again.
3. Exhaustive combinational check: all 8 combinations of (`inA`, `inB`, `sel`) with WIDTH = 1 → `out` equals `mux2`.
   - (1,0,0) → 1
   - (1,0,1) → 0
   - (0,1,1) → 1
4. Register latency: with `clk` period 10 ns, set `inA` = 1, `sel` = 0 before edge n → `out_q` = 1 after edge n, not before.
5. Async reset: assert `rst` mid-cycle while `out_q` = 1 and `sel_changes` = 3 → both read 0 immediately, without waiting for a clock. `out` is unaffected.
6. Counter wrap: CNT_W = 2, toggle `sel` every clock for 5 edges after reset → `sel_changes` reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and golden 2:1 select function for the mux library
// Contents:
//   DEFAULT_WIDTH : default data width for mux_data_flow
//   DEFAULT_CNT_W : default width of the select-change counter
//   MUX2_MAX_W    : widest data the mux2() reference function handles
//   mux2(a, b, s) : returns s ? b : a (zero-extended to MUX2_MAX_W)
package mux_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;
    localparam int MUX2_MAX_W    = 64;

    // Reference model for structural/behavioural variants; X/Z on s
    // merges a and b exactly like the ?: operator in the dataflow mux.
    function automatic logic [MUX2_MAX_W-1:0] mux2(
        input logic [MUX2_MAX_W-1:0] a,
        input logic [MUX2_MAX_W-1:0] b,
        input logic                  s
    );
        return s ? b : a;
    endfunction

endpackage

// File: rtl/mux2_comb.sv
// rtl/mux2_comb.sv - dataflow 2:1 multiplexer, no storage
// Ports:
//   a_i : data selected when s_i = 0
//   b_i : data selected when s_i = 1
//   s_i : select
//   y_o : s_i ? b_i : a_i
module mux2_comb #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/mux_data_flow.sv
// rtl/mux_data_flow.sv - reference 2:1 selector with registered output and select-change counter
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   inA         : data selected when sel = 0
//   inB         : data selected when sel = 1
//   sel         : select
//   out         : combinational mux result (valid during reset)
//   out_q       : out registered on clk
//   sel_changes : count of edges where sampled sel differs from the previous sample (wraps)
module mux_data_flow
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic [WIDTH-1:0] out_q_q, out_q_d;
    logic             sel_q_q, sel_q_d;
    logic [CNT_W-1:0] sel_changes_q, sel_changes_d;

    mux2_comb #(
        .WIDTH(WIDTH)
    ) u_mux2_comb (
        .a_i(inA),
        .b_i(inB),
        .s_i(sel),
        .y_o(out)
    );

    always_comb begin
        out_q_d       = out;
        sel_q_d       = sel;
        sel_changes_d = sel_changes_q;
        // An unknown sel makes the compare X, which falls through as "no change".
        if (sel != sel_q_q) begin
            sel_changes_d = sel_changes_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_q       <= '0;
            sel_q_q       <= 1'b0;
            sel_changes_q <= '0;
        end else begin
            out_q_q       <= out_q_d;
            sel_q_q       <= sel_q_d;
            sel_changes_q <= sel_changes_d;
        end
    end

    assign out_q       = out_q_q;
    assign sel_changes = sel_changes_q;

endmodule

// File: tb/tb_mux_data_flow.sv
// tb/tb_mux_data_flow.sv - directed self-checking bench for mux_data_flow
module tb_mux_data_flow;
    import mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;

    logic       inA = 1'b0;
    logic       inB = 1'b0;
    logic       out;
    logic       out_q;
    logic [1:0] sel_changes;

    logic [7:0] inA8 = 8'h00;
    logic [7:0] inB8 = 8'h00;
    logic [7:0] out8;
    logic [7:0] out_q8;
    logic [7:0] sel_changes8;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    mux_data_flow #(.WIDTH(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .sel(sel),
        .out(out), .out_q(out_q), .sel_changes(sel_changes)
    );

    mux_data_flow #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .inA(inA8), .inB(inB8), .sel(sel),
        .out(out8), .out_q(out_q8), .sel_changes(sel_changes8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] combo;
        logic       exp_tab [8];
        logic [1:0] cnt2_exp [5];
        logic [7:0] cnt8_exp [5];

        // index = {inA, inB, sel}
        exp_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        cnt2_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        cnt8_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};

        // Reset values, applied asynchronously
        #1 rst = 1'b1;
        #1;
        check("reset_out_q", 64'(out_q), 64'd0);
        check("reset_cnt", 64'(sel_changes), 64'd0);
        check("reset_out_q8", 64'(out_q8), 64'd0);
        #8;

        // Static select then select flip, held in reset: out must track inputs
        inA8 = 8'hA5;
        inB8 = 8'h3C;
        for (int k = 0; k < 50; k++) begin
            logic ea, eb, es;
            ea  = 1'(k % 2);
            eb  = 1'((k / 5) % 2);
            es  = (k >= 20 && k < 40);
            inA = ea;
            inB = eb;
            sel = es;
            #1;
            check($sformatf("flow_out_k%0d", k), 64'(out), 64'(es ? eb : ea));
            check($sformatf("flow_out8_k%0d", k), 64'(out8), es ? 64'h3C : 64'hA5);
            #9;
        end
        check("flow_out_q_in_reset", 64'(out_q), 64'd0);

        // Exhaustive 1-bit combinations
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            inA = combo[2];
            inB = combo[1];
            sel = combo[0];
            #1;
            check($sformatf("comb_%0d%0d%0d", combo[2], combo[1], combo[0]), 64'(out), 64'(exp_tab[i]));
            check($sformatf("mux2_fn_%0d", i), mux2(64'(combo[2]), 64'(combo[1]), combo[0]), 64'(exp_tab[i]));
            #1;
        end

        // Unknown select merges differing bits to X
        inA  = 1'b1;
        inB  = 1'b1;
        inA8 = 8'hF0;
        inB8 = 8'hF5;
        sel  = 1'bx;
        #1;
        check("selx_out_same", 64'(out), 64'd1);
        check("selx_out8_merge", 64'(out8), {56'd0, 8'b1111_0x0x});
        sel = 1'b0;

        // Register latency
        @(negedge clk);
        rst  = 1'b0;
        sel  = 1'b0;
        inA  = 1'b1;
        inB  = 1'b0;
        inA8 = 8'h5A;
        inB8 = 8'hC3;
        #3;
        check("lat_out_q_before_edge", 64'(out_q), 64'd0);
        check("lat_out_now", 64'(out), 64'd1);
        @(negedge clk);
        check("lat_out_q_after_edge", 64'(out_q), 64'd1);
        check("lat_out_q8_after_edge", 64'(out_q8), 64'h5A);
        check("lat_cnt_no_change", 64'(sel_changes), 64'd0);

        // Pulse between edges is invisible to the counter
        #1 sel = 1'b1;
        #2 sel = 1'b0;
        @(negedge clk);
        check("glitch_cnt", 64'(sel_changes), 64'd0);
        check("glitch_cnt8", 64'(sel_changes8), 64'd0);

        // Build up three changes with out = 1
        inB = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        check("cnt_1", 64'(sel_changes), 64'd1);
        sel = 1'b0;
        @(negedge clk);
        check("cnt_2", 64'(sel_changes), 64'd2);
        sel = 1'b1;
        @(negedge clk);
        check("cnt_3", 64'(sel_changes), 64'd3);
        check("pre_rst_out_q", 64'(out_q), 64'd1);
        check("pre_rst_out_q8", 64'(out_q8), 64'hC3);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("arst_out_q", 64'(out_q), 64'd0);
        check("arst_cnt", 64'(sel_changes), 64'd0);
        check("arst_out_q8", 64'(out_q8), 64'd0);
        check("arst_cnt8", 64'(sel_changes8), 64'd0);
        check("arst_out", 64'(out), 64'd1);
        check("arst_out8", 64'(out8), 64'hC3);

        // Counter wrap: sel = 1 at first post-reset edge, toggling every clock
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("wrap_cnt_e%0d", i + 1), 64'(sel_changes), 64'(cnt2_exp[i]));
            check($sformatf("wrap_cnt8_e%0d", i + 1), 64'(sel_changes8), 64'(cnt8_exp[i]));
            sel = ~sel;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
